// File: rtl/hw2_clockgate_core.sv
// Two-stage clock-gated datapath computing d = (a +/- b) * c, low 16 bits.
// Operand and product registers sit behind latch-based ICGs that close when c is zero.
module hw2_clockgate_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic        s,
  output logic [15:0] d
);

  // Add is a zero-extended 9-bit sum; subtract is a sign-extended 9-bit difference.
  function automatic logic signed [15:0] ext_op(input logic [7:0] x, input logic [7:0] y,
                                                input logic sel);
    logic [8:0] sum9;
    logic [8:0] dif9;
    sum9 = {1'b0, x} + {1'b0, y};
    dif9 = {1'b0, x} - {1'b0, y};
    ext_op = sel ? $signed({7'd0, sum9}) : $signed({{7{dif9[8]}}, dif9});
  endfunction

  function automatic logic [15:0] trunc16(input logic signed [31:0] v);
    trunc16 = v[15:0];
  endfunction

  logic        en1;
  logic        en2;
  logic        en1_lat;
  logic        en2_lat;
  logic        gclk1;
  logic        gclk2;

  logic [7:0]  a_p1;
  logic [7:0]  b_p1;
  logic        s_p1;
  logic [7:0]  c_p1;
  logic        zero_p1;

  logic signed [15:0] op_p1;
  logic signed [15:0] cx_p1;
  logic signed [31:0] prod_p1;

  logic [15:0] p_p2;
  logic        zero_p2;

  assign en1 = (c != 8'd0);
  assign en2 = !zero_p1;

  // Enables pass only while clk is low, so gclk cannot glitch during the high phase.
  always_latch begin
    if (!reset) begin
      en1_lat <= 1'b0;
      en2_lat <= 1'b0;
    end else if (!clk) begin
      en1_lat <= en1;
      en2_lat <= en2;
    end
  end

  assign gclk1 = clk & en1_lat;
  assign gclk2 = clk & en2_lat;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_p1    <= 8'd0;
      zero_p1 <= 1'b0;
    end else begin
      c_p1    <= c;
      zero_p1 <= (c == 8'd0);
    end
  end

  always_ff @(posedge gclk1 or negedge reset) begin
    if (!reset) begin
      a_p1 <= 8'd0;
      b_p1 <= 8'd0;
      s_p1 <= 1'b0;
    end else begin
      a_p1 <= a;
      b_p1 <= b;
      s_p1 <= s;
    end
  end

  always_comb begin
    op_p1   = ext_op(a_p1, b_p1, s_p1);
    cx_p1   = $signed({8'd0, c_p1});
    prod_p1 = op_p1 * cx_p1;
  end

  // ---- stage 2: product register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_p2 <= 1'b0;
    end else begin
      zero_p2 <= zero_p1;
    end
  end

  always_ff @(posedge gclk2 or negedge reset) begin
    if (!reset) begin
      p_p2 <= 16'd0;
    end else begin
      p_p2 <= trunc16(prod_p1);
    end
  end

  // A stale p_p2 is masked whenever the gated stage skipped an update.
  assign d = zero_p2 ? 16'h0000 : p_p2;

endmodule

// File: tb/tb_hw2_clockgate_core.sv
// Bench for hw2_clockgate_core: directed vector table, gating and reset sequences,
// plus random traffic against a two-deep history model of the arithmetic.
module tb_hw2_clockgate_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic        s;
  logic [15:0] d;

  int checks   = 0;
  int failures = 0;

  int g1cnt = 0;
  int g2cnt = 0;

  // Model state: result of the previous sampled operand set, and gating history.
  logic [15:0] prev_f;
  logic        prev_nz;
  logic [7:0]  last_a;
  logic [7:0]  last_b;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  hw2_clockgate_core dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .s     (s),
    .d     (d)
  );

  always #5 clk = ~clk;

  always @(posedge dut.gclk1) g1cnt++;
  always @(posedge dut.gclk2) g2cnt++;

  function automatic logic [15:0] ref_f(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] m, input logic sel);
    int v;
    v = sel ? (int'(x) + int'(y)) : (int'(x) - int'(y));
    return 16'(v * int'(m));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    prev_f  = 16'h0000;
    prev_nz = 1'b1;
    last_a  = 8'h00;
    last_b  = 8'h00;
  endtask

  // Called at posedge+1: drive inputs, take one edge, check d and gate activity.
  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m,
                      input logic sel, input logic chk_gate);
    int g1b;
    int g2b;
    logic [15:0] exp_d;
    a = x; b = y; c = m; s = sel;
    g1b = g1cnt;
    g2b = g2cnt;
    @(posedge clk);
    #1;
    exp_d   = prev_f;
    check("model_d", {16'd0, d}, {16'd0, exp_d});
    if (chk_gate) begin
      check("gclk1_pulse", g1cnt - g1b, (m != 8'd0) ? 1 : 0);
      check("gclk2_pulse", g2cnt - g2b, prev_nz ? 1 : 0);
    end
    if (m != 8'd0) begin
      last_a = x;
      last_b = y;
    end else if (chk_gate) begin
      check("a_hold", {24'd0, dut.a_p1}, {24'd0, last_a});
      check("b_hold", {24'd0, dut.b_p1}, {24'd0, last_b});
    end
    prev_f  = ref_f(x, y, m, sel);
    prev_nz = (m != 8'd0);
  endtask

  initial begin
    reset = 1'b0;
    a = 8'h00; b = 8'h00; c = 8'h00; s = 1'b0;
    model_reset();

    #1;
    check("reset_d_t0", {16'd0, d}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); s = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_d_hold", {16'd0, d}, 32'd0);
    end

    reset = 1'b1;
    step(8'h10, 8'h05, 8'h03, 1'b1, 1'b1);
    check("post_reset_first", {16'd0, d}, 32'd0);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("post_reset_add", {16'd0, d}, 32'h003F);

    tbl.push_back('{8'h10, 8'h05, 8'h03, 1'b1, 16'h003F});
    tbl.push_back('{8'h10, 8'h05, 8'h03, 1'b0, 16'h0021});
    tbl.push_back('{8'h05, 8'h10, 8'h02, 1'b0, 16'hFFEA});
    tbl.push_back('{8'hFF, 8'hFF, 8'hFF, 1'b1, 16'hFC02});
    tbl.push_back('{8'h00, 8'hFF, 8'hFF, 1'b0, 16'h01FF});
    tbl.push_back('{8'h80, 8'h7F, 8'h02, 1'b0, 16'h0002});
    tbl.push_back('{8'hFF, 8'h00, 8'h01, 1'b1, 16'h00FF});
    tbl.push_back('{8'h01, 8'h01, 8'h01, 1'b1, 16'h0002});
    tbl.push_back('{8'h02, 8'h01, 8'h03, 1'b0, 16'h0003});
    tbl.push_back('{8'hFF, 8'h01, 8'h02, 1'b1, 16'h0200});
    tbl.push_back('{8'h03, 8'h00, 8'h00, 1'b1, 16'h0000});

    // Streamed back to back: d after vector i's edge reflects vector i-1.
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size())
        step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, 1'b1);
      else
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      if (i > 0)
        check($sformatf("tbl_%0d", i - 1), {16'd0, d}, {16'd0, tbl[i - 1].exp});
    end

    // Several c=0 cycles in a row: gates closed, d held at zero.
    step(8'h33, 8'h11, 8'h07, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom), 8'($urandom), 8'h00, 1'($urandom), 1'b1);
      if (i > 0) check("zero_run_d", {16'd0, d}, 32'd0);
    end
    step(8'h09, 8'h04, 8'h05, 1'b0, 1'b1);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    check("wake_from_zero", {16'd0, d}, 32'h0019);

    // Alternate c=0 and random nonzero c for 200 cycles.
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0)
        step(8'($urandom), 8'($urandom), 8'h00, 1'($urandom), 1'b1);
      else
        step(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1'($urandom), 1'b1);
      if (i % 2 == 1) check("alt_zero_d", {16'd0, d}, 32'd0);
    end

    // Fully random traffic, then reset asserted between edges mid-stream.
    for (int i = 0; i < 60; i++)
      step(8'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255)),
           1'($urandom), 1'b1);
    step(8'h20, 8'h01, 8'h04, 1'b1, 1'b1);
    step(8'h20, 8'h01, 8'h04, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_async_d", {16'd0, d}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_d", {16'd0, d}, 32'd0);
    #2;
    reset = 1'b1;
    model_reset();
    step(8'h07, 8'h02, 8'h03, 1'b0, 1'b1);
    check("rst_resume_0", {16'd0, d}, 32'd0);
    step(8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    check("rst_resume_1", {16'd0, d}, 32'h000F);
    for (int i = 0; i < 30; i++)
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
